// File: rtl/w5300_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : w5300_bus_arbiter_pkg
// Description : Shared W5300 definitions: RD/WR flag values, op-word layout,
//               arbiter state encodings and the default completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package w5300_bus_arbiter_pkg;

    // Direction flag carried in bit 10 of the op word
    localparam logic c_RD = 1'b1;
    localparam logic c_WR = 1'b0;

    // Op word presented to w5300_interface: {flag, 10-bit register address}
    typedef struct packed {
        logic       flag;
        logic [9:0] addr;
    } op_word_t;

    // Idle value of the interface op word: a read of address 0
    localparam op_word_t c_OP_RESET = '{flag: c_RD, addr: 10'h000};

    // Arbiter state encodings
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_RESP  = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;

    // Default cycles to wait for interface completion
    localparam int c_TIMEOUT_DEFAULT = 6000;

endpackage
`default_nettype wire

// File: rtl/w5300_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : w5300_rr_picker
// Description : Combinational round-robin selector. Returns the first set
//               request at or after the pointer (modulo N) as one-hot plus index.
// Revision    : 1.0 - initial release
// ============================================================================
module w5300_rr_picker #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    int w_scan;

    // Scan N slots starting at the pointer; the first requester found wins
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_scan  = 0;
        for (int k = 0; k < N; k++) begin
            w_scan = int'(i_ptr) + k;
            if (w_scan >= N) begin
                w_scan = w_scan - N;
            end
            if (!o_valid && i_req[w_scan]) begin
                o_valid       = 1'b1;
                o_gnt[w_scan] = 1'b1;
                o_idx         = PW'(w_scan);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/w5300_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : w5300_bus_arbiter
// Description : Round-robin arbiter sharing the w5300_interface control port
//               among N requesters, one outstanding access at a time, with a
//               per-requester lock that keeps the grant across bursts.
//               Optional macro W5300_ARB_TIMEOUT_EN bounds the wait for
//               interface completion (TIMEOUT cycles, then err=1).
// Revision    : 1.0 - initial release
// ============================================================================
module w5300_bus_arbiter
    import w5300_bus_arbiter_pkg::*;
#(
    parameter int N             = 5,
    parameter int LOCK_IDLE_MAX = 64,
    parameter int TIMEOUT       = c_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*11-1:0] op_addr,
    input  logic [N*16-1:0] op_wr_data,
    output logic [N-1:0]    ack,
    output logic            err,
    output logic [15:0]     rd_data,
    output logic [N-1:0]    gnt,
    output logic            if_start,
    output logic [10:0]     if_addr,
    output logic [15:0]     if_wr_data,
    input  logic [15:0]     if_rd_data,
    input  logic            if_done
);

    localparam int c_PW      = $clog2(N);
    localparam int c_CNT_MAX = (TIMEOUT > LOCK_IDLE_MAX) ? TIMEOUT : LOCK_IDLE_MAX;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    logic [2:0]         r_state_q,      w_state_d;
    logic [c_PW-1:0]    r_ptr_q,        w_ptr_d;
    logic [c_PW-1:0]    r_owner_q,      w_owner_d;
    logic [N-1:0]       r_gnt_q,        w_gnt_d;
    logic [N-1:0]       r_ack_q,        w_ack_d;
    logic [15:0]        r_rd_data_q,    w_rd_data_d;
    logic               r_if_start_q,   w_if_start_d;
    logic [10:0]        r_if_addr_q,    w_if_addr_d;
    logic [15:0]        r_if_wr_data_q, w_if_wr_data_d;
    logic [c_CNT_W-1:0] r_cnt_q,        w_cnt_d;
    logic               r_err_q,        w_err_d;

    logic [N-1:0]       w_pick_gnt;
    logic [c_PW-1:0]    w_pick_idx;
    logic               w_pick_valid;
    logic [c_PW-1:0]    w_lat_idx;
    int                 w_lat_sel;
    logic               w_release;
    logic               w_force_rel;

    w5300_rr_picker #(
        .N  (N),
        .PW (c_PW)
    ) u_picker (
        .i_req   (req),
        .i_ptr   (r_ptr_q),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // A timed-out access drops the grant even when its owner holds lock
`ifdef W5300_ARB_TIMEOUT_EN
    assign w_force_rel = r_err_q;
    assign err         = r_err_q;
`else
    assign w_force_rel = 1'b0;
    assign err         = 1'b0;
`endif

    // Operands come from the new winner in IDLE, from the lock owner in HOLD
    assign w_lat_idx = (r_state_q == c_ST_HOLD) ? r_owner_q : w_pick_idx;
    assign w_lat_sel = int'(w_lat_idx);

    // Next-state and datapath logic for the access sequencer
    always_comb begin
        w_state_d      = r_state_q;
        w_ptr_d        = r_ptr_q;
        w_owner_d      = r_owner_q;
        w_gnt_d        = r_gnt_q;
        w_ack_d        = '0;
        w_rd_data_d    = r_rd_data_q;
        w_if_start_d   = 1'b0;
        w_if_addr_d    = r_if_addr_q;
        w_if_wr_data_d = r_if_wr_data_q;
        w_cnt_d        = r_cnt_q;
        w_err_d        = 1'b0;
        w_release      = 1'b0;

        case (r_state_q)
            c_ST_IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_d        = w_pick_gnt;
                    w_owner_d      = w_pick_idx;
                    w_if_addr_d    = op_addr[11*w_lat_sel +: 11];
                    w_if_wr_data_d = op_wr_data[16*w_lat_sel +: 16];
                    w_state_d      = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_if_start_d = 1'b1;
                w_cnt_d      = '0;
                w_state_d    = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (if_done) begin
                    w_ack_d     = r_gnt_q;
                    w_rd_data_d = if_rd_data;
                    w_state_d   = c_ST_RESP;
                end
`ifdef W5300_ARB_TIMEOUT_EN
                else if (r_cnt_q == c_CNT_W'(TIMEOUT - 1)) begin
                    w_ack_d     = r_gnt_q;
                    w_rd_data_d = '0;
                    w_err_d     = 1'b1;
                    w_state_d   = c_ST_RESP;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
`endif
            end
            c_ST_RESP: begin
                if (lock[r_owner_q] && !w_force_rel) begin
                    w_cnt_d   = '0;
                    w_state_d = c_ST_HOLD;
                end else begin
                    w_release = 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (req[r_owner_q]) begin
                    w_if_addr_d    = op_addr[11*w_lat_sel +: 11];
                    w_if_wr_data_d = op_wr_data[16*w_lat_sel +: 16];
                    w_cnt_d        = '0;
                    w_state_d      = c_ST_ISSUE;
                end else if (!lock[r_owner_q]) begin
                    w_release = 1'b1;
                end else if (r_cnt_q == c_CNT_W'(LOCK_IDLE_MAX - 1)) begin
                    w_release = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase

        // Releasing the bus rotates priority to the slot after the owner
        if (w_release) begin
            w_gnt_d   = '0;
            w_ptr_d   = (r_owner_q == c_PW'(N - 1)) ? '0 : r_owner_q + c_PW'(1);
            w_state_d = c_ST_IDLE;
        end
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= c_ST_IDLE;
            r_ptr_q        <= '0;
            r_owner_q      <= '0;
            r_gnt_q        <= '0;
            r_ack_q        <= '0;
            r_rd_data_q    <= '0;
            r_if_start_q   <= 1'b0;
            r_if_addr_q    <= c_OP_RESET;
            r_if_wr_data_q <= '0;
            r_cnt_q        <= '0;
            r_err_q        <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_ptr_q        <= w_ptr_d;
            r_owner_q      <= w_owner_d;
            r_gnt_q        <= w_gnt_d;
            r_ack_q        <= w_ack_d;
            r_rd_data_q    <= w_rd_data_d;
            r_if_start_q   <= w_if_start_d;
            r_if_addr_q    <= w_if_addr_d;
            r_if_wr_data_q <= w_if_wr_data_d;
            r_cnt_q        <= w_cnt_d;
            r_err_q        <= w_err_d;
        end
    end

    assign ack        = r_ack_q;
    assign rd_data    = r_rd_data_q;
    assign gnt        = r_gnt_q;
    assign if_start   = r_if_start_q;
    assign if_addr    = r_if_addr_q;
    assign if_wr_data = r_if_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_w5300_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_w5300_bus_arbiter
// Description : Directed self-checking bench for w5300_bus_arbiter with a
//               simple w5300_interface responder (if_done 4 cycles after
//               if_start). Timeout scenario built when W5300_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w5300_bus_arbiter;

    localparam int N = 5;
`ifdef W5300_ARB_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 6000;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    lock = '0;
    logic [N*11-1:0] op_addr = '0;
    logic [N*16-1:0] op_wr_data = '0;
    logic [N-1:0]    ack;
    logic            err;
    logic [15:0]     rd_data;
    logic [N-1:0]    gnt;
    logic            if_start;
    logic [10:0]     if_addr;
    logic [15:0]     if_wr_data;
    logic [15:0]     if_rd_data = '0;
    logic            if_done = 1'b0;

    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          dly_cnt = 0;
    int          stray_at = -1;
    int          n_ack = 0;
    int          n_start = 0;
    bit          resp_en = 1'b1;
    logic [15:0] rd_val = '0;

    w5300_bus_arbiter #(
        .N             (N),
        .LOCK_IDLE_MAX (64),
        .TIMEOUT       (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lock       (lock),
        .op_addr    (op_addr),
        .op_wr_data (op_wr_data),
        .ack        (ack),
        .err        (err),
        .rd_data    (rd_data),
        .gnt        (gnt),
        .if_start   (if_start),
        .if_addr    (if_addr),
        .if_wr_data (if_wr_data),
        .if_rd_data (if_rd_data),
        .if_done    (if_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Interface responder: completion 4 cycles after launch, plus stray pulses
    always @(negedge clk) begin
        if_done = 1'b0;
        if (cyc == stray_at) if_done = 1'b1;
        if (dly_cnt > 0) begin
            dly_cnt = dly_cnt - 1;
            if (dly_cnt == 0) begin
                if_done    = 1'b1;
                if_rd_data = rd_val;
            end
        end
        if (if_start && resp_en) dly_cnt = 4;
        if (ack != '0) n_ack = n_ack + 1;
        if (if_start) n_start = n_start + 1;
    end

    task automatic wait_ack(input int max, output int n);
        int i;
        i = 0;
        n = -1;
        while (n < 0 && i < max) begin
            @(negedge clk);
            i++;
            if (ack != '0) n = i;
        end
    endtask

    task automatic wait_start(input int max, output int n);
        int i;
        i = 0;
        n = -1;
        while (n < 0 && i < max) begin
            @(negedge clk);
            i++;
            if (if_start) n = i;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nvec++; if (ack !== 5'b0) begin nerr++; $display("FAIL rst_ack: got %b want %b", ack, 5'b0); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rst_err: got %b want 0", err); end
        nvec++; if (rd_data !== 16'h0) begin nerr++; $display("FAIL rst_rd_data: got %h want 0000", rd_data); end
        nvec++; if (gnt !== 5'b0) begin nerr++; $display("FAIL rst_gnt: got %b want %b", gnt, 5'b0); end
        nvec++; if (if_start !== 1'b0) begin nerr++; $display("FAIL rst_if_start: got %b want 0", if_start); end
        nvec++; if (if_addr !== 11'h400) begin nerr++; $display("FAIL rst_if_addr: got %h want 400", if_addr); end
        nvec++; if (if_wr_data !== 16'h0) begin nerr++; $display("FAIL rst_if_wr_data: got %h want 0000", if_wr_data); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (gnt !== 5'b0) begin nerr++; $display("FAIL idle_gnt: got %b want %b", gnt, 5'b0); end
    endtask

    task automatic test_single_write;
        int n;
        op_addr[11*1 +: 11]    = {1'b0, 10'h018};
        op_wr_data[16*1 +: 16] = 16'hC0A8;
        req = 5'b00010;
        wait_start(20, n);
        nvec++; if (n !== 2) begin nerr++; $display("FAIL wr_start_lat: got %0d want 2", n); end
        nvec++; if (if_addr !== 11'h018) begin nerr++; $display("FAIL wr_if_addr: got %h want 018", if_addr); end
        nvec++; if (if_wr_data !== 16'hC0A8) begin nerr++; $display("FAIL wr_if_wr_data: got %h want c0a8", if_wr_data); end
        nvec++; if (gnt !== 5'b00010) begin nerr++; $display("FAIL wr_gnt: got %b want %b", gnt, 5'b00010); end
        wait_ack(20, n);
        nvec++; if (n !== 5) begin nerr++; $display("FAIL wr_ack_lat: got %0d want 5", n); end
        nvec++; if (ack !== 5'b00010) begin nerr++; $display("FAIL wr_ack: got %b want %b", ack, 5'b00010); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL wr_err: got %b want 0", err); end
        req = 5'b0;
        @(negedge clk);
        nvec++; if (ack !== 5'b0) begin nerr++; $display("FAIL wr_ack_pulse: got %b want %b", ack, 5'b0); end
        nvec++; if (gnt !== 5'b0) begin nerr++; $display("FAIL wr_gnt_rel: got %b want %b", gnt, 5'b0); end
    endtask

    task automatic test_single_read;
        int n;
        op_addr[11*3 +: 11] = {1'b1, 10'h0FE};
        rd_val = 16'h5300;
        req = 5'b01000;
        wait_start(20, n);
        nvec++; if (n < 0) begin nerr++; $display("FAIL rd_start: got timeout want if_start"); end
        // Operands changed after grant must not reach the interface
        op_addr[11*3 +: 11]    = {1'b0, 10'h3FF};
        op_wr_data[16*3 +: 16] = 16'hFFFF;
        wait_ack(20, n);
        nvec++; if (ack !== 5'b01000) begin nerr++; $display("FAIL rd_ack: got %b want %b", ack, 5'b01000); end
        nvec++; if (rd_data !== 16'h5300) begin nerr++; $display("FAIL rd_data: got %h want 5300", rd_data); end
        nvec++; if (if_addr !== 11'h4FE) begin nerr++; $display("FAIL rd_if_addr_latched: got %h want 4fe", if_addr); end
        nvec++; if (if_wr_data !== 16'h0) begin nerr++; $display("FAIL rd_if_wr_latched: got %h want 0000", if_wr_data); end
        req = 5'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_done;
        stray_at = cyc + 2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nvec++; if (ack !== 5'b0 || gnt !== 5'b0) begin nerr++; $display("FAIL stray_done: got ack %b gnt %b want 0 0", ack, gnt); end
        end
        stray_at = -1;
    endtask

    task automatic test_round_robin;
        int n;
        int a0;
        int s0;
        logic [N-1:0] exp;
        do_reset();
        a0 = n_ack;
        s0 = n_start;
        req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            exp = 5'b00001 << (k % N);
            wait_ack(40, n);
            nvec++; if (ack !== exp) begin nerr++; $display("FAIL rr_ack%0d: got %b want %b", k, ack, exp); end
            nvec++; if (gnt !== exp) begin nerr++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, exp); end
            if (k == 5) req = 5'b0;
        end
        repeat (8) @(negedge clk);
        nvec++; if (n_ack - a0 !== 6) begin nerr++; $display("FAIL rr_ack_count: got %0d want 6", n_ack - a0); end
        nvec++; if (n_start - s0 !== 6) begin nerr++; $display("FAIL rr_start_count: got %0d want 6", n_start - s0); end
    endtask

    task automatic test_lock_burst;
        int n;
        op_addr[11*4 +: 11] = {1'b1, 10'h200};
        rd_val = 16'h0A0B;
        lock = 5'b10000;
        req  = 5'b10001;
        for (int k = 0; k < 3; k++) begin
            wait_ack(40, n);
            nvec++; if (ack !== 5'b10000) begin nerr++; $display("FAIL lock_burst_ack%0d: got %b want %b", k, ack, 5'b10000); end
            if (k == 2) begin
                req  = 5'b00001;
                lock = 5'b0;
            end
        end
        wait_ack(40, n);
        nvec++; if (ack !== 5'b00001) begin nerr++; $display("FAIL lock_next_ack: got %b want %b", ack, 5'b00001); end
        req = 5'b0;
        @(negedge clk);
    endtask

    task automatic test_lock_idle;
        int n;
        lock = 5'b00100;
        req  = 5'b00100;
        wait_ack(40, n);
        nvec++; if (ack !== 5'b00100) begin nerr++; $display("FAIL idle_lock_ack: got %b want %b", ack, 5'b00100); end
        req = 5'b00001;
        n = 0;
        while (gnt == 5'b00100 && n < 200) begin
            @(negedge clk);
            n++;
        end
        nvec++; if (n !== 65) begin nerr++; $display("FAIL idle_release_cycles: got %0d want 65", n); end
        nvec++; if (gnt !== 5'b0) begin nerr++; $display("FAIL idle_gnt_rel: got %b want %b", gnt, 5'b0); end
        @(negedge clk);
        nvec++; if (gnt !== 5'b00001) begin nerr++; $display("FAIL idle_next_gnt: got %b want %b", gnt, 5'b00001); end
        wait_ack(40, n);
        nvec++; if (ack !== 5'b00001) begin nerr++; $display("FAIL idle_next_ack: got %b want %b", ack, 5'b00001); end
        req  = 5'b0;
        lock = 5'b0;
        @(negedge clk);
    endtask

`ifdef W5300_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        resp_en = 1'b0;
        lock = 5'b00100;
        req  = 5'b00100;
        wait_start(20, n);
        nvec++; if (n < 0) begin nerr++; $display("FAIL tmo_start: got timeout want if_start"); end
        wait_ack(60, n);
        nvec++; if (n !== 20) begin nerr++; $display("FAIL tmo_lat: got %0d want 20", n); end
        nvec++; if (ack !== 5'b00100) begin nerr++; $display("FAIL tmo_ack: got %b want %b", ack, 5'b00100); end
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL tmo_err: got %b want 1", err); end
        nvec++; if (rd_data !== 16'h0) begin nerr++; $display("FAIL tmo_rd_data: got %h want 0000", rd_data); end
        req = 5'b0;
        @(negedge clk);
        nvec++; if (gnt !== 5'b0) begin nerr++; $display("FAIL tmo_gnt_rel: got %b want %b", gnt, 5'b0); end
        stray_at = cyc + 2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++; if (ack !== 5'b0 || err !== 1'b0) begin nerr++; $display("FAIL tmo_late_done: got ack %b err %b want 0 0", ack, err); end
        end
        stray_at = -1;
        lock = 5'b0;
        resp_en = 1'b1;
    endtask
`endif

    task automatic test_reset_mid_wait;
        int n;
        resp_en = 1'b0;
        op_addr[11*1 +: 11]    = {1'b0, 10'h155};
        op_wr_data[16*1 +: 16] = 16'h1234;
        req = 5'b00010;
        wait_start(20, n);
        nvec++; if (n !== 2) begin nerr++; $display("FAIL mid_start_lat: got %0d want 2", n); end
        repeat (2) @(negedge clk);
        nvec++; if (gnt !== 5'b00010) begin nerr++; $display("FAIL mid_gnt_before: got %b want %b", gnt, 5'b00010); end
        rst = 1'b1;
        #1;
        nvec++; if (gnt !== 5'b0) begin nerr++; $display("FAIL mid_rst_gnt: got %b want %b", gnt, 5'b0); end
        nvec++; if (if_addr !== 11'h400) begin nerr++; $display("FAIL mid_rst_if_addr: got %h want 400", if_addr); end
        nvec++; if (if_wr_data !== 16'h0) begin nerr++; $display("FAIL mid_rst_if_wr: got %h want 0000", if_wr_data); end
        @(posedge clk);
        #1;
        nvec++; if (ack !== 5'b0 || if_start !== 1'b0 || rd_data !== 16'h0) begin nerr++; $display("FAIL mid_rst_edge: got ack %b start %b rd %h want 0 0 0000", ack, if_start, rd_data); end
        req = 5'b0;
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (gnt !== 5'b0) begin nerr++; $display("FAIL mid_post_gnt: got %b want %b", gnt, 5'b0); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_stray_done();
        test_round_robin();
        test_lock_burst();
        test_lock_idle();
`ifdef W5300_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
